// File: rtl/hilo_md_if.sv
// EX-stage HI/LO request/write bus between the pipeline (master) and hilo_md_unit (slave).
interface hilo_md_if;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (output flush, start, op, src_a, src_b,
                  input  stallreq, hi_we, lo_we, hi_o, lo_o);
  modport slave  (input  flush, start, op, src_a, src_b,
                  output stallreq, hi_we, lo_we, hi_o, lo_o);
endinterface

// File: rtl/hilo_md_unit.sv
// HI/LO writer: MULT/MULTU/DIV/DIVU iterative (sign-magnitude), MTHI/MTLO pass-through.
// Define HILO_FAST_MUL_EN for a single-cycle combinational multiply.
module hilo_md_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  hilo_md_if.slave  bus
);
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0]      opnd;   // multiplicand or divisor magnitude
  logic             neg_q, neg_r, is_div;

  logic        is_signed, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic        op_mul, op_div, op_mthi, op_mtlo;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.src_a[31];
  assign b_neg     = is_signed & bus.src_b[31];
  assign abs_a     = a_neg ? -bus.src_a : bus.src_a;
  assign abs_b     = b_neg ? -bus.src_b : bus.src_b;
  assign op_mul    = bus.start && (bus.op[2:1] == 2'b00);
  assign op_div    = bus.start && (bus.op[2:1] == 2'b01);
  assign op_mthi   = bus.start && (bus.op == 3'b100);
  assign op_mtlo   = bus.start && (bus.op == 3'b101);

  // shift-add step: add multiplicand into upper half when multiplier LSB set, then shift right
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'h0)};
  assign mul_nx  = {mul_sum, acc[31:1]};

  // restoring step: shifted remainder needs 33 bits before the trial subtract
  logic [32:0] div_top;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_nx;
  assign div_top  = acc[63:31];
  assign div_ge   = div_top >= {1'b0, opnd};
  assign div_diff = div_top[31:0] - opnd;
  assign div_nx   = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;
  assign prod_fix = neg_q ? -acc : acc;
  assign res_hi   = is_div ? (neg_r ? -acc[63:32] : acc[63:32]) : prod_fix[63:32];
  assign res_lo   = is_div ? (neg_q ? -acc[31:0]  : acc[31:0])  : prod_fix[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.stallreq = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.hi_o     = 32'h0;
    bus.lo_o     = 32'h0;
    case (state)
      IDLE: begin
        if (op_mthi) begin
          bus.hi_we = 1'b1;
          bus.hi_o  = bus.src_a;
        end else if (op_mtlo) begin
          bus.lo_we = 1'b1;
          bus.lo_o  = bus.src_a;
        end else if (op_mul) begin
          bus.stallreq = 1'b1;
`ifdef HILO_FAST_MUL_EN
          state_nx = DONE;
`else
          state_nx = MUL;
`endif
        end else if (op_div) begin
          bus.stallreq = 1'b1;
          state_nx     = (bus.src_b == 32'h0) ? DONE : DIV;
        end
      end
      MUL: begin
        bus.stallreq = 1'b1;
        if (cnt == CNT_W'(MUL_CYCLES - 1)) state_nx = DONE;
      end
      DIV: begin
        bus.stallreq = 1'b1;
        if (cnt == CNT_W'(DIV_CYCLES - 1)) state_nx = DONE;
      end
      DONE: begin
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.hi_o  = res_hi;
        bus.lo_o  = res_lo;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      state_nx  = IDLE;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.hi_o  = 32'h0;
      bus.lo_o  = 32'h0;
    end
    // outputs are combinational, so hold them low for the whole reset window
    if (rst) begin
      bus.stallreq = 1'b0;
      bus.hi_we    = 1'b0;
      bus.lo_we    = 1'b0;
      bus.hi_o     = 32'h0;
      bus.lo_o     = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op_mul) begin
            is_div <= 1'b0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= 1'b0;
`ifdef HILO_FAST_MUL_EN
            acc <= 64'(abs_a) * 64'(abs_b);
`else
            acc  <= {32'h0, abs_b};
            opnd <= abs_a;
`endif
          end else if (op_div) begin
            is_div <= 1'b1;
            if (bus.src_b == 32'h0) begin
              acc   <= {bus.src_a, 32'hFFFF_FFFF};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              acc   <= {32'h0, abs_a};
              opnd  <= abs_b;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        MUL: begin
          acc <= mul_nx;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_nx;
          cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: vector table for mul/div results and latency, plus
// hand sequences for MTHI/MTLO, flush and asynchronous reset.
module tb_hilo_md_unit;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;
`ifdef HILO_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;
  localparam int NV   = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hilo_md_if bus();

  hilo_md_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = s; bus.op = o; bus.src_a = a; bus.src_b = b;
  endtask

  // issue an op at edge+1, hold it while stalled, measure latency to the write pulse
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int lat, stalls;
    @(posedge clk); #1;
    drive(1'b1, o, a, b);
    #1;
    lat = 0;
    stalls = bus.stallreq ? 1 : 0;
    while (!(bus.hi_we || bus.lo_we) && lat < 100) begin
      @(posedge clk); #2;
      lat++;
      if (bus.stallreq) stalls++;
    end
    chk({name, " latency"}, 64'(lat), 64'(elat));
    chk({name, " stalls"}, 64'(stalls), 64'(elat));
    chk({name, " we"}, {62'h0, bus.hi_we, bus.lo_we}, 64'h3);
    chk({name, " hi"}, 64'(bus.hi_o), 64'(ehi));
    chk({name, " lo"}, 64'(bus.lo_o), 64'(elo));
    bus.start = 1'b0;
    @(posedge clk); #2;
    chk({name, " idle after"}, {61'h0, bus.stallreq, bus.hi_we, bus.lo_we}, 64'h0);
  endtask

  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MLAT};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, MLAT};
    vecs[2]  = '{OP_MULTU, 32'h5,         32'h6,         32'h0,         32'd30,        MLAT};
    vecs[3]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         MLAT};
    vecs[4]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         MLAT};
    vecs[5]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         MLAT};
    vecs[6]  = '{OP_MULT,  32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MLAT};
    vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DLAT};
    vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT};
    vecs[9]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DLAT};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, DLAT};
    vecs[11] = '{OP_DIVU,  32'h8000_0000, 32'h3,         32'h2,         32'h2AAA_AAAA, DLAT};
    vecs[12] = '{OP_DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, DLAT};
    vecs[13] = '{OP_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         32'h1,         DLAT};
    vecs[14] = '{OP_DIVU,  32'h3,         32'h5,         32'h3,         32'h0,         DLAT};
    vecs[15] = '{OP_DIV,   32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 1};
    vecs[16] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
    vecs[17] = '{OP_DIV,   32'h8000_0000, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 1};

    bus.flush = 1'b0;
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    #12;
    chk("reset outputs", {bus.stallreq, bus.hi_we, bus.lo_we, bus.hi_o, bus.lo_o}, 64'h0);
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MTHI / MTLO: same-cycle write, no stall
    @(posedge clk); #1;
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0); #1;
    chk("mthi", {bus.stallreq, bus.hi_we, bus.lo_we, bus.hi_o, bus.lo_o},
        {3'b010, 32'hDEAD_BEEF, 32'h0});
    @(posedge clk); #1;
    drive(1'b1, OP_MTLO, 32'h1357_9BDF, 32'h0); #1;
    chk("mtlo", {bus.stallreq, bus.hi_we, bus.lo_we, bus.hi_o, bus.lo_o},
        {3'b001, 32'h0, 32'h1357_9BDF});
    @(posedge clk); #1;
    drive(1'b1, OP_MTHI, 32'hCAFE_F00D, 32'h0); bus.flush = 1'b1; #1;
    chk("mthi flushed", {bus.stallreq, bus.hi_we, bus.lo_we, bus.hi_o, bus.lo_o}, 64'h0);
    bus.flush = 1'b0;
    drive(1'b0, OP_MULT, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // flush DIVU at cycle 10: no write pulse may follow
    begin
      int bad;
      @(posedge clk); #1;
      drive(1'b1, OP_DIVU, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (bus.hi_we || bus.lo_we || bus.stallreq) bad++;
        @(posedge clk); #1;
      end
      chk("flush div quiet", 64'(bad), 64'h0);
    end
    run_op("post-flush multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, MLAT);

    // flush in the DONE cycle suppresses the write
    @(posedge clk); #1;
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    repeat (DLAT) @(posedge clk);
    #1; bus.flush = 1'b1; #1;
    chk("flush in done", {bus.hi_we, bus.lo_we, bus.hi_o, bus.lo_o}, 66'h0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0; #1;
    chk("flush done idle", {bus.stallreq, bus.hi_we, bus.lo_we}, 3'b000);

    // asynchronous reset mid-DIV with the op still presented
    @(posedge clk); #1;
    drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h2); #1;
    chk("div start stall", 64'(bus.stallreq), 64'h1);
    repeat (20) @(posedge clk);
    #3; rst = 1'b1; #1;
    chk("async rst outputs", {bus.stallreq, bus.hi_we, bus.lo_we, bus.hi_o, bus.lo_o}, 64'h0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post-rst multu", OP_MULTU, 32'h5, 32'h6, 32'h0, 32'd30, MLAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
